// File: rtl/conv3_window_gen.sv
// 3x3 sliding-window generator over a raster-order feature map: two line buffers
// feed a 3x3 shift window; one window is emitted per interior sample, one cycle late.
module conv3_window_gen #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] win_out [0:2][0:2],
  output logic              valid_out,
  output logic              frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  win_q [0:2][0:2];
  logic [DATA_W-1:0]  win_d [0:2][0:2];

  // lb_old holds row r-2, lb_new holds row r-1
  logic [DATA_W-1:0]  lb_old [0:IMG_W-1];
  logic [DATA_W-1:0]  lb_new [0:IMG_W-1];

  logic               col_last_s;
  logic               row_last_s;
  logic [DATA_W-1:0]  lb_old_rd_s;
  logic [DATA_W-1:0]  lb_new_rd_s;

  assign col_last_s  = (col_q == COL_LAST);
  assign row_last_s  = (row_q == ROW_LAST);
  assign lb_old_rd_s = lb_old[col_q];
  assign lb_new_rd_s = lb_new[col_q];

  // Next-state logic for position counters, FILL/STREAM state and output flags
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (valid_in) begin
      if (col_last_s) begin
        col_d = COL_ZERO;
        if (row_last_s) begin
          row_d = ROW_ZERO;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_ONE;
        row_d = row_q;
      end
      // Only full-width columns of rows >= 2 form a window; none straddles a row edge
      valid_d = (state_q == ST_STREAM) && (col_q >= COL_TWO);
      done_d  = row_last_s && col_last_s;
      case (state_q)
        ST_FILL: begin
          if ((row_q == ROW_ONE) && col_last_s) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_STREAM: begin
          if (row_last_s && col_last_s) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_STREAM;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Window shift: columns move left, new right column comes from the line buffers and pix_in
  always_comb begin
    win_d = win_q;
    if (valid_in) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb_old_rd_s;
      win_d[1][2] = lb_new_rd_s;
      win_d[2][2] = pix_in;
    end else begin
      win_d = win_q;
    end
  end

  // Control and window registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      col_q   <= COL_ZERO;
      row_q   <= ROW_ZERO;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  // Line buffers are overwritten by rows 0/1 of each frame before use, so no reset
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb_old[col_q] <= lb_new_rd_s;
      lb_new[col_q] <= pix_in;
    end
  end

  assign win_out    = win_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: doc/conv3_window_gen.md
CONV3_WINDOW_GEN -- requirements
Module: conv3_window_gen

Interface
REQ-001 Parameter DATA_W, default 32, is the width of one feature-map sample.
REQ-002 Parameter IMG_W, default 14, is the input feature-map width in samples (range 3..1024).
REQ-003 Parameter IMG_H, default 14, is the input feature-map height in rows (range 3..1024).
REQ-004 The block SHALL have a port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have a port rst_n, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have a port pix_in, input, width DATA_W: raster-order sample (row-major, left to right, top to bottom).
REQ-007 The block SHALL have a port valid_in, input, width 1: pix_in is valid this cycle.
REQ-008 The block SHALL have a port win_out[0:2][0:2], output, DATA_W each: 3x3 window, unpacked to match the conv3 consumer input.
REQ-009 The block SHALL have a port valid_out, output, width 1: win_out holds a new complete window this cycle.
REQ-010 The block SHALL have a port frame_done, output, width 1: one-cycle pulse coincident with the last window of a frame.

Function
REQ-011 The block SHALL hold two line buffers of IMG_W x DATA_W, storing rows r-1 and r-2, plus a 3x3 shift-register window.
REQ-012 The block SHALL keep a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1), both advancing only on cycles with valid_in=1.
REQ-013 Counter update: col increments per accepted sample; at IMG_W-1, col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1), both wrap to 0 (next frame).
REQ-014 The block SHALL have two states: FILL (row<2) and STREAM (row>=2); FILL->STREAM on acceptance of sample (1, IMG_W-1); STREAM->FILL on acceptance of sample (IMG_H-1, IMG_W-1).
REQ-015 On each accepted sample, column c of the window SHALL shift left: new right column = {linebuf_r-2[col], linebuf_r-1[col], pix_in} for rows 0,1,2 respectively.
REQ-016 On each accepted sample, the line buffers SHALL be updated: linebuf_r-2[col] <= linebuf_r-1[col] and linebuf_r-1[col] <= pix_in.
REQ-017 Orientation: win_out[i][j] = sample at (row-2+i, col-2+j) of the accepted sample (i = 0 is oldest row, j = 0 is leftmost column).
REQ-018 valid_out SHALL be 1 exactly one cycle after accepting a sample with row>=2 and col>=2, and 0 otherwise; latency = 1 cycle.
REQ-019 The block SHALL produce (IMG_W-2)*(IMG_H-2) valid windows per frame (stride 1, no padding); no window SHALL straddle a row boundary.
REQ-020 When valid_in=0, no counter, line buffer or window register SHALL change, valid_out SHALL be 0, and win_out SHALL hold its last value.
REQ-021 There is no backpressure: the consumer accepts every valid_out; gaps of any length in valid_in SHALL be tolerated with identical window contents.
REQ-022 frame_done SHALL be 1 in the same cycle as the valid_out produced by sample (IMG_H-1, IMG_W-1), and 0 otherwise.
REQ-023 Back-to-back frames (sample (0,0) of frame n+1 in the cycle after the last sample of frame n) SHALL be accepted with no bubble; stale line-buffer data SHALL NOT appear in any valid window.
REQ-024 Samples are passed unmodified (no arithmetic); widths are preserved exactly.

Reset
REQ-025 While rst_n=0, col, row, valid_out, frame_done and all win_out elements SHALL be 0, and the state SHALL be FILL; line-buffer contents need not be reset.
REQ-026 Reset asserted mid-frame SHALL abort the frame; the first accepted sample after release SHALL be treated as (0,0).

Verification
REQ-027 14x14 frame, pix = r*14+c, valid_in continuously high -> first valid_out one cycle after accepting pix 30, win_out = {0,1,2; 14,15,16; 28,29,30}.
REQ-028 Same frame -> exactly 144 valid_out pulses; last window = {165,166,167; 179,180,181; 193,194,195} with frame_done=1 in that cycle only.
REQ-029 Same frame with random valid_in gaps (0-5 idle cycles) -> identical sequence of 144 windows; valid_out never high during an idle cycle's response slot.
REQ-030 Row boundary: accepted samples (3,0) and (3,1) -> no valid_out; sample (3,2)=44 -> win_out = {14,15,16; 28,29,30; 42,43,44}.
REQ-031 Two back-to-back frames, second frame pix = 1000+r*14+c -> first window of frame 2 = {1000,1001,1002; 1014,1015,1016; 1028,1029,1030}.
REQ-032 Reset pulsed after 50 accepted samples, then a full frame -> all outputs 0 during reset; the subsequent frame produces the same 144 windows as REQ-028.
